// File: rtl/tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tx_arbiter: round-robin byte arbiter feeding a serial transmitter.       |
// | Define TX_ARB_IFG_EN to insert a one-bit inter-frame gap. Rev 1.0        |
// +--------------------------------------------------------------------------+
module tx_arbiter #(
    parameter int          NREQ = 4,
    parameter logic [15:0] DIV0 = 16'd5208,
    parameter logic [15:0] DIV1 = 16'd2604,
    parameter logic [15:0] DIV2 = 16'd868,
    parameter logic [15:0] DIV3 = 16'd434
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3:0]        cfg_data_length,
    input  logic [1:0]        cfg_parity_type,
    input  logic [1:0]        cfg_baud_rate,
    output logic              tx_send,
    output logic [7:0]        tx_data,
    output logic [3:0]        tx_data_length,
    output logic [1:0]        tx_parity_type,
    output logic [1:0]        tx_baud_rate,
    output logic              busy,
    output logic [1:0]        grant_id
);

`ifdef TX_ARB_IFG_EN
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, FRAME = 2'd2, GAP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, FRAME = 2'd2} state_t;
`endif

    state_t      state;
    state_t      state_next;
    logic [15:0] cyc_cnt;
    logic [3:0]  bit_cnt;
    logic [15:0] div_m1;
    logic        cyc_done;
    logic [3:0]  last_bit;
    logic [NREQ-1:0] grant_raw;
    logic [1:0]  sel_idx;
    logic [1:0]  idx;
    logic        found;
    logic        xfer;
    logic [3:0]  len_clamped;

    // Round-robin search begins one past the last winner.
    always_comb begin
        grant_raw = '0;
        sel_idx   = grant_id;
        idx       = '0;
        found     = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = grant_id + 2'(k);
            if (!found && req_valid[idx]) begin
                grant_raw[idx] = 1'b1;
                sel_idx        = idx;
                found          = 1'b1;
            end
        end
    end

    assign req_ready = (state == IDLE && !reset) ? grant_raw : '0;
    assign xfer      = |req_ready;
    assign tx_send   = (state == START) && !reset;
    assign busy      = (state != IDLE) && !reset;

    always_comb begin
        len_clamped = cfg_data_length;
        if (cfg_data_length < 4'd5)
            len_clamped = 4'd5;
        else if (cfg_data_length > 4'd8)
            len_clamped = 4'd8;
    end

    always_comb begin
        div_m1 = DIV0 - 16'd1;
        case (tx_baud_rate)
            2'd0:    div_m1 = DIV0 - 16'd1;
            2'd1:    div_m1 = DIV1 - 16'd1;
            2'd2:    div_m1 = DIV2 - 16'd1;
            default: div_m1 = DIV3 - 16'd1;
        endcase
    end

    // FRAME carries bits 1..B-1, i.e. bit_cnt runs 0..L+parity.
    assign cyc_done = (cyc_cnt == div_m1);
    assign last_bit = tx_data_length + {3'b000, |tx_parity_type};

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (xfer) state_next = START;
            START: if (cyc_done) state_next = FRAME;
            FRAME: begin
                if (cyc_done && bit_cnt == last_bit)
`ifdef TX_ARB_IFG_EN
                    state_next = GAP;
`else
                    state_next = IDLE;
`endif
            end
`ifdef TX_ARB_IFG_EN
            GAP:   if (cyc_done) state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
        end else if (state_next != state) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
        end else if (state != IDLE) begin
            if (cyc_done) begin
                cyc_cnt <= '0;
                bit_cnt <= bit_cnt + 4'd1;
            end else begin
                cyc_cnt <= cyc_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data        <= 8'h00;
            tx_data_length <= 4'd8;
            tx_parity_type <= 2'd0;
            tx_baud_rate   <= 2'd0;
            grant_id       <= 2'd3;
        end else if (xfer) begin
            tx_data        <= req_data[{sel_idx, 3'b000} +: 8];
            tx_data_length <= len_clamped;
            tx_parity_type <= cfg_parity_type;
            tx_baud_rate   <= cfg_baud_rate;
            grant_id       <= sel_idx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_arbiter.sv
`default_nettype none
// Directed testbench for tx_arbiter (DIV0..3 = 4,3,2,1).
module tb_tx_arbiter;

`ifdef TX_ARB_IFG_EN
    localparam int IFG = 1;
`else
    localparam int IFG = 0;
`endif

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  cfg_data_length;
    logic [1:0]  cfg_parity_type;
    logic [1:0]  cfg_baud_rate;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic [3:0]  tx_data_length;
    logic [1:0]  tx_parity_type;
    logic [1:0]  tx_baud_rate;
    logic        busy;
    logic [1:0]  grant_id;

    int vectors = 0;
    int errors  = 0;

    tx_arbiter #(
        .NREQ(4), .DIV0(16'd4), .DIV1(16'd3), .DIV2(16'd2), .DIV3(16'd1)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .cfg_data_length(cfg_data_length), .cfg_parity_type(cfg_parity_type),
        .cfg_baud_rate(cfg_baud_rate),
        .tx_send(tx_send), .tx_data(tx_data), .tx_data_length(tx_data_length),
        .tx_parity_type(tx_parity_type), .tx_baud_rate(tx_baud_rate),
        .busy(busy), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts negedges while busy; returns at the first idle negedge.
    task automatic count_frame(output int busy_n, output int send_n);
        busy_n = 0;
        send_n = 0;
        for (int i = 0; i < 400 && busy; i++) begin
            busy_n++;
            if (tx_send) send_n++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 4'hF;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (req_ready !== 4'h0) begin errors++; $display("FAIL rst_ready: got %h want 0", req_ready); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (tx_send !== 1'b0) begin errors++; $display("FAIL rst_send: got %b want 0", tx_send); end
        vectors++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", tx_data); end
        vectors++; if (tx_data_length !== 4'd8) begin errors++; $display("FAIL rst_len: got %0d want 8", tx_data_length); end
        vectors++; if (tx_parity_type !== 2'd0) begin errors++; $display("FAIL rst_par: got %0d want 0", tx_parity_type); end
        vectors++; if (tx_baud_rate !== 2'd0) begin errors++; $display("FAIL rst_baud: got %0d want 0", tx_baud_rate); end
        vectors++; if (grant_id !== 2'd3) begin errors++; $display("FAIL rst_grant: got %0d want 3", grant_id); end
        reset = 1'b0;
        req_valid = 4'h0;
        #1;
        vectors++; if (req_ready !== 4'h0) begin errors++; $display("FAIL novalid_ready: got %h want 0", req_ready); end
        @(negedge clk);
    endtask

    task automatic test_single();
        int b, s;
        req_valid = 4'b0001; req_data = 32'h0000_00A5;
        cfg_data_length = 4'd8; cfg_parity_type = 2'd0; cfg_baud_rate = 2'd0;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        vectors++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", tx_data); end
        vectors++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_grant: got %0d want 0", grant_id); end
        count_frame(b, s);
        vectors++; if (s !== 4) begin errors++; $display("FAIL single_send: got %0d want 4", s); end
        vectors++; if (b !== 40 + 4*IFG) begin errors++; $display("FAIL single_busy: got %0d want %0d", b, 40 + 4*IFG); end
    endtask

    task automatic test_round_robin();
        int b, s, e;
        pulse_reset();
        req_valid = 4'hF; req_data = 32'h4433_2211;
        cfg_data_length = 4'd8; cfg_parity_type = 2'd0; cfg_baud_rate = 2'd3;
        for (int k = 0; k < 5; k++) begin
            e = k % 4;
            #1;
            vectors++; if (req_ready !== 4'(1 << e)) begin errors++; $display("FAIL rr_ready%0d: got %b want %b", k, req_ready, 4'(1 << e)); end
            @(negedge clk);
            if (k == 4) req_valid = 4'h0;
            vectors++; if (grant_id !== 2'(e)) begin errors++; $display("FAIL rr_grant%0d: got %0d want %0d", k, grant_id, e); end
            vectors++; if (tx_data !== 8'(8'h11 * (e + 1))) begin errors++; $display("FAIL rr_data%0d: got %h want %h", k, tx_data, 8'(8'h11 * (e + 1))); end
            count_frame(b, s);
            vectors++; if (b !== 10 + IFG) begin errors++; $display("FAIL rr_busy%0d: got %0d want %0d", k, b, 10 + IFG); end
        end
    endtask

    task automatic test_clamp();
        int b, s;
        req_valid = 4'b0001; req_data = 32'h0000_005A;
        cfg_data_length = 4'd3; cfg_parity_type = 2'd2; cfg_baud_rate = 2'd1;
        @(negedge clk);
        req_valid = 4'b0000;
        vectors++; if (tx_data_length !== 4'd5) begin errors++; $display("FAIL clamp_lo: got %0d want 5", tx_data_length); end
        vectors++; if (tx_parity_type !== 2'd2) begin errors++; $display("FAIL clamp_par: got %0d want 2", tx_parity_type); end
        count_frame(b, s);
        vectors++; if (b !== 24 + 3*IFG) begin errors++; $display("FAIL clamp_busy: got %0d want %0d", b, 24 + 3*IFG); end
        req_valid = 4'b0001;
        cfg_data_length = 4'd12; cfg_parity_type = 2'd0; cfg_baud_rate = 2'd3;
        @(negedge clk);
        req_valid = 4'b0000;
        vectors++; if (tx_data_length !== 4'd8) begin errors++; $display("FAIL clamp_hi: got %0d want 8", tx_data_length); end
        count_frame(b, s);
        vectors++; if (b !== 10 + IFG) begin errors++; $display("FAIL clamp_hi_busy: got %0d want %0d", b, 10 + IFG); end
    endtask

    task automatic test_cfg_change();
        int b, s;
        req_valid = 4'b0001;
        cfg_data_length = 4'd8; cfg_parity_type = 2'd0; cfg_baud_rate = 2'd0;
        @(negedge clk);
        req_valid = 4'b0000;
        b = 0;
        for (int i = 0; i < 400 && busy; i++) begin
            if (b == 10) begin cfg_baud_rate = 2'd3; cfg_data_length = 4'd5; end
            b++;
            @(negedge clk);
        end
        vectors++; if (b !== 40 + 4*IFG) begin errors++; $display("FAIL cfg_busy: got %0d want %0d", b, 40 + 4*IFG); end
        vectors++; if (tx_baud_rate !== 2'd0) begin errors++; $display("FAIL cfg_baud_held: got %0d want 0", tx_baud_rate); end
        vectors++; if (tx_data_length !== 4'd8) begin errors++; $display("FAIL cfg_len_held: got %0d want 8", tx_data_length); end
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = 4'b0000;
        vectors++; if (tx_baud_rate !== 2'd3) begin errors++; $display("FAIL cfg_baud_new: got %0d want 3", tx_baud_rate); end
        vectors++; if (tx_data_length !== 4'd5) begin errors++; $display("FAIL cfg_len_new: got %0d want 5", tx_data_length); end
        count_frame(b, s);
        vectors++; if (b !== 7 + IFG) begin errors++; $display("FAIL cfg_busy_new: got %0d want %0d", b, 7 + IFG); end
    endtask

    task automatic test_reset_midframe();
        int b, s;
        req_valid = 4'b0001;
        cfg_data_length = 4'd8; cfg_parity_type = 2'd0; cfg_baud_rate = 2'd0;
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        req_valid = 4'hF;
        #1;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        vectors++; if (req_ready !== 4'h0) begin errors++; $display("FAIL mid_rst_ready: got %b want 0", req_ready); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %b want 0", busy); end
        vectors++; if (tx_send !== 1'b0) begin errors++; $display("FAIL post_rst_send: got %b want 0", tx_send); end
        vectors++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL post_rst_ready: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'h0;
        vectors++; if (grant_id !== 2'd0) begin errors++; $display("FAIL post_rst_grant: got %0d want 0", grant_id); end
        count_frame(b, s);
        vectors++; if (b !== 40 + 4*IFG) begin errors++; $display("FAIL post_rst_busy_len: got %0d want %0d", b, 40 + 4*IFG); end
    endtask

    task automatic test_back_to_back();
        int b, s;
        pulse_reset();
        req_valid = 4'b0011; req_data = 32'h0000_BBAA;
        cfg_data_length = 4'd8; cfg_parity_type = 2'd1; cfg_baud_rate = 2'd2;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL b2b_ready0: got %b want 0001", req_ready); end
        @(negedge clk);
        vectors++; if (tx_parity_type !== 2'd1) begin errors++; $display("FAIL b2b_par: got %0d want 1", tx_parity_type); end
        count_frame(b, s);
        vectors++; if (b !== 22 + 2*IFG) begin errors++; $display("FAIL b2b_busy0: got %0d want %0d", b, 22 + 2*IFG); end
        #1;
        vectors++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL b2b_ready1: got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'h0;
        vectors++; if (tx_data !== 8'hBB) begin errors++; $display("FAIL b2b_data1: got %h want bb", tx_data); end
        count_frame(b, s);
        vectors++; if (b !== 22 + 2*IFG) begin errors++; $display("FAIL b2b_busy1: got %0d want %0d", b, 22 + 2*IFG); end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 4'h0;
        req_data = 32'h0;
        cfg_data_length = 4'd8;
        cfg_parity_type = 2'd0;
        cfg_baud_rate = 2'd0;
        test_reset();
        test_single();
        test_round_robin();
        test_clamp();
        test_cfg_change();
        test_reset_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
